// File: rtl/ultrasonic_echo_responder_pkg.sv
// Shared definitions for the ultrasonic ranging blocks: FSM encoding, counter width
// and the cycle-count derivations that the controller also uses.
package ultrasonic_pkg;

    localparam int CNT_W = 21;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HIGH,
        DELAY,
        ECHO,
        HOLDOFF
    } state_t;

    function automatic longint count_us(input longint clk_mhz, input longint us);
        return clk_mhz * us;
    endfunction

    function automatic longint count_ms(input longint clk_mhz, input longint ms);
        return clk_mhz * ms * 1000;
    endfunction

    function automatic bit count_fits(input longint count);
        return count < (longint'(1) << CNT_W);
    endfunction

endpackage

// File: rtl/ultrasonic_echo_responder_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// Sensor-side emulation of the trigger/echo ranging protocol: validates the trigger,
// waits the sensor delay, then drives an echo whose width encodes the distance.
module ultrasonic_echo_responder
    import ultrasonic_pkg::*;
#(
    parameter int CLK_MHZ       = 50,
    parameter int MIN_TRIG_US   = 10,
    parameter int ECHO_DELAY_US = 750,
    parameter int NO_OBJECT_MS  = 30,
    parameter int HOLDOFF_MS    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             trigger,
    input  logic             object_present,
    input  logic [CNT_W-1:0] echo_cycles,
    output logic             echo,
    output logic             busy,
    output logic             echo_done,
    output logic             trig_error,
    output logic             trig_overrun
);

    localparam longint MIN_TRIG_L = count_us(CLK_MHZ, MIN_TRIG_US);
    localparam longint DELAY_L    = count_us(CLK_MHZ, ECHO_DELAY_US);
    localparam longint NO_OBJ_L   = count_ms(CLK_MHZ, NO_OBJECT_MS);
    localparam longint HOLDOFF_L  = count_ms(CLK_MHZ, HOLDOFF_MS);

    localparam cnt_t COUNT_MIN_TRIG = cnt_t'(MIN_TRIG_L);
    localparam cnt_t COUNT_NO_OBJ   = cnt_t'(NO_OBJ_L);
    localparam cnt_t LAST_DELAY     = cnt_t'(DELAY_L - 1);
    localparam cnt_t LAST_HOLDOFF   = cnt_t'(HOLDOFF_L - 1);

    generate
        if (!count_fits(MIN_TRIG_L) || !count_fits(DELAY_L) ||
            !count_fits(NO_OBJ_L)   || !count_fits(HOLDOFF_L)) begin : g_count_range
            $error("ultrasonic_echo_responder: a derived cycle count does not fit the counter");
        end
    endgenerate

    logic   trig_s, trig_d, rise;
    state_t state, state_n;
    cnt_t   cnt, cnt_n, cnt_inc, width, width_n;
    logic   echo_n, done_n, err_n, ovr_n;

    sync_2ff #(.W(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trigger),
        .q     (trig_s)
    );

    assign rise    = trig_s & ~trig_d;
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d       <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            width        <= '0;
            echo         <= 1'b0;
            echo_done    <= 1'b0;
            trig_error   <= 1'b0;
            trig_overrun <= 1'b0;
        end else begin
            trig_d       <= trig_s;
            state        <= state_n;
            cnt          <= cnt_n;
            width        <= width_n;
            echo         <= echo_n;
            echo_done    <= done_n;
            trig_error   <= err_n;
            trig_overrun <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        width_n = width;
        echo_n  = echo;
        done_n  = 1'b0;
        err_n   = 1'b0;
        ovr_n   = 1'b0;
        // Disable wins over everything, including a pending echo_done or overrun.
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            echo_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_n = TRIG_HIGH;
                        cnt_n   = cnt_t'(1);
                    end
                end
                TRIG_HIGH: begin
                    if (trig_s) begin
                        cnt_n = cnt_inc;
                    end else if (cnt >= COUNT_MIN_TRIG) begin
                        state_n = DELAY;
                        cnt_n   = '0;
                        if (!object_present)
                            width_n = COUNT_NO_OBJ;
                        else if (echo_cycles == '0)
                            width_n = cnt_t'(1);
                        else
                            width_n = echo_cycles;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        err_n   = 1'b1;
                    end
                end
                DELAY: begin
                    ovr_n = rise;
                    if (cnt == LAST_DELAY) begin
                        state_n = ECHO;
                        cnt_n   = '0;
                        echo_n  = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                ECHO: begin
                    ovr_n = rise;
                    if (cnt == width - 1'b1) begin
                        state_n = HOLDOFF;
                        cnt_n   = '0;
                        echo_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                HOLDOFF: begin
                    // Only a fresh rise is accepted later, so a trigger held high here is ignored.
                    ovr_n = rise;
                    if (cnt == LAST_HOLDOFF) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    echo_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder at CLK_MHZ=1: stimulus queues timed
// output events, a negedge monitor matches every observed event against the queue.
module tb_ultrasonic_echo_responder;

    localparam int EV_RISE  = 0;
    localparam int EV_FALL  = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ERR   = 3;
    localparam int EV_OVR   = 4;
    localparam int EV_BUSYF = 5;
    localparam int EV_ZERO  = 6;
    localparam int MAX_CYC  = 80000;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        trigger = 1'b0;
    logic        object_present = 1'b1;
    logic [20:0] echo_cycles = '0;
    logic        echo, busy, echo_done, trig_error, trig_overrun;

    ev_t exp_q[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    bit  stim_done = 1'b0;

    ultrasonic_echo_responder #(.CLK_MHZ(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .trigger        (trigger),
        .object_present (object_present),
        .echo_cycles    (echo_cycles),
        .echo           (echo),
        .busy           (busy),
        .echo_done      (echo_done),
        .trig_error     (trig_error),
        .trig_overrun   (trig_overrun)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic string ev_name(input int k);
        case (k)
            EV_RISE:  return "echo_rise";
            EV_FALL:  return "echo_fall";
            EV_DONE:  return "echo_done";
            EV_ERR:   return "trig_error";
            EV_OVR:   return "trig_overrun";
            EV_BUSYF: return "busy_fall";
            EV_ZERO:  return "all_zero";
            default:  return "unknown";
        endcase
    endfunction

    task automatic push(input int k, input int c);
        exp_q.push_back('{kind: k, cyc: c});
    endtask

    task automatic check_ev(input int k);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got event at cycle %0d, required no event", ev_name(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                miscompares++;
                $display("FAIL %s: got %s@%0d, required %s@%0d",
                         ev_name(e.kind), ev_name(k), cyc, ev_name(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: owns all counters and the summary.
    initial begin
        bit  p_echo, p_busy;
        ev_t e;
        p_echo = 1'b0;
        p_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (echo && !p_echo) check_ev(EV_RISE);
            if (!echo && p_echo) check_ev(EV_FALL);
            if (echo_done)       check_ev(EV_DONE);
            if (trig_error)      check_ev(EV_ERR);
            if (trig_overrun)    check_ev(EV_OVR);
            if (!busy && p_busy) check_ev(EV_BUSYF);
            if (exp_q.size() > 0 && exp_q[0].kind == EV_ZERO && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                vectors++;
                if ({echo, busy, echo_done, trig_error, trig_overrun} != 5'b0) begin
                    miscompares++;
                    $display("FAIL all_zero@%0d: got outputs %b, required 00000", cyc,
                             {echo, busy, echo_done, trig_error, trig_overrun});
                end
            end
            p_echo = echo;
            p_busy = busy;
            if (stim_done || cyc > MAX_CYC) begin
                if (!stim_done) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL timeout: got cycle %0d, required finish by %0d", cyc, MAX_CYC);
                end
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL %s: got nothing, required event at cycle %0d",
                             ev_name(e.kind), e.cyc);
                end
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Drives trigger high for n cycles from the current negedge; c is the cycle it was dropped.
    task automatic trig_pulse(input int n, output int c);
        trigger = 1'b1;
        repeat (n) @(negedge clk);
        trigger = 1'b0;
        c = cyc;
    endtask

    initial begin
        int c, c2, r;
        @(negedge clk);
        push(EV_ZERO, 3);
        wait_to(4);
        rst_n  = 1'b1;
        enable = 1'b1;
        object_present = 1'b1;
        echo_cycles    = 21'd580;
        wait_to(cyc + 5);

        // Too short, and one below the minimum.
        trig_pulse(5, c);
        push(EV_ERR, c + 3); push(EV_BUSYF, c + 3);
        wait_to(c + 10);
        trig_pulse(9, c);
        push(EV_ERR, c + 3); push(EV_BUSYF, c + 3);
        wait_to(c + 10);

        // Nominal: rise 752 edges after the low sample, 580 wide, holdoff 10000.
        trig_pulse(12, c);
        r = c + 753;
        push(EV_RISE, r); push(EV_FALL, r + 580); push(EV_DONE, r + 580);
        push(EV_BUSYF, r + 580 + 10000);
        wait_to(r + 10590);

        // Minimum-length trigger, zero width -> 1 cycle; width change in DELAY ignored.
        echo_cycles = 21'd0;
        trig_pulse(10, c);
        r = c + 753;
        push(EV_RISE, r); push(EV_FALL, r + 1); push(EV_DONE, r + 1);
        push(EV_BUSYF, r + 1 + 10000);
        wait_to(c + 100);
        echo_cycles = 21'd500;
        wait_to(r + 10010);

        // Overrun in ECHO and HOLDOFF, then trigger held through the end of HOLDOFF.
        echo_cycles = 21'd200;
        trig_pulse(12, c);
        r = c + 753;
        push(EV_RISE, r); push(EV_OVR, r + 53);
        push(EV_FALL, r + 200); push(EV_DONE, r + 200);
        push(EV_OVR, r + 303); push(EV_OVR, r + 10003); push(EV_BUSYF, r + 10200);
        wait_to(r + 50);
        trig_pulse(3, c2);
        wait_to(r + 300);
        trig_pulse(3, c2);
        wait_to(r + 10000);
        trigger = 1'b1;
        wait_to(r + 10300);
        trigger = 1'b0;
        wait_to(r + 10320);
        trig_pulse(5, c);
        push(EV_ERR, c + 3); push(EV_BUSYF, c + 3);
        wait_to(c + 10);

        // No object: 30000-cycle echo, then disable during HOLDOFF.
        object_present = 1'b0;
        echo_cycles    = 21'd580;
        trig_pulse(12, c);
        r = c + 753;
        push(EV_RISE, r); push(EV_FALL, r + 30000); push(EV_DONE, r + 30000);
        wait_to(r + 30100);
        push(EV_BUSYF, cyc + 1);
        enable = 1'b0;
        wait_to(cyc + 3);
        enable = 1'b1;
        object_present = 1'b1;

        // Disable mid-DELAY: no echo ever appears.
        echo_cycles = 21'd100;
        trig_pulse(12, c);
        wait_to(c + 300);
        push(EV_BUSYF, cyc + 1);
        enable = 1'b0;
        wait_to(cyc + 2);
        enable = 1'b1;
        wait_to(c + 1000);

        // Reset mid-ECHO must drop echo before the next clock edge.
        trig_pulse(12, c);
        r = c + 753;
        push(EV_RISE, r);
        wait_to(r + 20);
        @(posedge clk);
        #2;
        push(EV_FALL, cyc); push(EV_BUSYF, cyc); push(EV_ZERO, cyc);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_to(cyc + 5);
        stim_done = 1'b1;
    end

endmodule

// File: doc/ultrasonic_echo_responder.md
Name: ultrasonic_echo_responder

Overview:
- Emulates the sensor end of the trigger/echo ranging protocol: it accepts a trigger pulse and answers with an echo pulse whose width encodes a programmed distance.
- Used in simulation and on-board hardware-in-loop to exercise the ranging controller without a physical transducer.
- Checks that the trigger is long enough, inserts the sensor's trigger-to-echo delay, models "no object" with a long echo, and enforces a re-arm holdoff.

Parameters:
- CLK_MHZ, 50, clock frequency in MHz.
- MIN_TRIG_US, 10, minimum valid trigger width in µs.
- ECHO_DELAY_US, 750, delay from trigger fall to echo rise in µs.
- NO_OBJECT_MS, 30, echo width in ms when no object is present.
- HOLDOFF_MS, 10, dead time after echo fall before a new trigger is accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  responder active; low aborts any transaction.
- trigger  in  1  trigger from the controller; asynchronous, synchronised internally.
- object_present  in  1  1 = use echo_cycles as the width; 0 = use the no-object width.
- echo_cycles  in  21  desired echo width in clk cycles.
- echo  out  1  echo pulse, registered.
- busy  out  1  high in every state except IDLE.
- echo_done  out  1  one-cycle pulse when echo falls.
- trig_error  out  1  one-cycle pulse when a trigger was too short.
- trig_overrun  out  1  one-cycle pulse when a trigger rising edge arrives while busy.

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset rst_n.
  - All outputs are 0, state is IDLE, counter and latched width are 0, synchroniser flops are 0.
  - Reset asserted mid-pulse drops echo immediately.
- Localparams:
  - COUNT_MIN_TRIG = CLK_MHZ*MIN_TRIG_US
  - COUNT_DELAY = CLK_MHZ*ECHO_DELAY_US
  - COUNT_NO_OBJ = CLK_MHZ*NO_OBJECT_MS*1000
  - COUNT_HOLDOFF = CLK_MHZ*HOLDOFF_MS*1000
  - Every COUNT_* must be < 2^21; the design fails elaboration otherwise.
- Synchroniser: 2-flop synchroniser on trigger gives trig_s; a further flop gives trig_d. The rise event is trig_s & ~trig_d.
- Counter: 21 bits, saturating at all-ones.
- IDLE:
  - On rise with enable=1, go to TRIG_HIGH with cnt=1.
- TRIG_HIGH:
  - While trig_s=1, cnt increments.
  - On trig_s=0 with cnt >= COUNT_MIN_TRIG: go to DELAY, cnt=0, latch the width W.
    - W = COUNT_NO_OBJ if object_present=0.
    - Otherwise W = echo_cycles, with 0 replaced by 1.
  - On trig_s=0 with cnt < COUNT_MIN_TRIG: go to IDLE and pulse trig_error.
- DELAY:
  - cnt increments.
  - On the edge where cnt == COUNT_DELAY-1: go to ECHO, cnt=0, echo<=1.
- ECHO:
  - cnt increments.
  - On the edge where cnt == W-1: go to HOLDOFF, cnt=0, echo<=0, pulse echo_done.
  - echo is high for exactly W cycles.
- HOLDOFF:
  - On the edge where cnt == COUNT_HOLDOFF-1: go to IDLE.
  - A trigger held high across HOLDOFF does not retrigger, because a rise event is required.
- Timing: let E be the first edge at which the synchroniser's first flop samples trigger low.
  - The FSM leaves TRIG_HIGH at E+2.
  - echo rises at E+2+COUNT_DELAY.
- Busy handling: a rise event in DELAY, ECHO or HOLDOFF pulses trig_overrun and is otherwise ignored.
- enable=0 in any state: at the next edge go to IDLE with echo<=0, cnt=0, and no echo_done.
- Input sampling: echo_cycles and object_present are sampled only at the TRIG_HIGH→DELAY edge; later changes do not affect the current pulse.
- Pulse exclusivity: echo_done, trig_error and trig_overrun never assert in the same cycle as reset.

Decomposition:
- Shared package ultrasonic_pkg holds:
  - State encoding: IDLE, TRIG_HIGH, DELAY, ECHO, HOLDOFF.
  - The 21-bit counter width constant.
  - The COUNT_* derivation functions, shared with the controller.
- Sub-module sync_2ff: a generic 2-flop synchroniser with rst_n.

Test Plan (CLK_MHZ=1, so COUNT_MIN_TRIG=10, COUNT_DELAY=750, COUNT_NO_OBJ=30000, COUNT_HOLDOFF=10000):
- Nominal: trigger high 12 cycles, object_present=1, echo_cycles=580 -> echo rises 752 cycles after the trigger-low sample, stays high 580 cycles, echo_done pulses once at the fall, busy clears 10000 cycles later.
- Short trigger: trigger high 5 cycles -> trig_error is a single 1-cycle pulse, echo stays 0, busy returns to 0.
- No object: object_present=0, valid trigger -> echo high exactly 30000 cycles.
- Edge width: echo_cycles=0 -> echo high 1 cycle; echo_cycles changed during DELAY -> width unchanged.
- Overrun and hold: trigger pulses during ECHO and HOLDOFF -> trig_overrun pulses, echo width unaffected; trigger held high through HOLDOFF -> no new echo until trigger falls and rises again.
- Abort: rst_n low mid-ECHO -> echo drops asynchronously and all outputs are 0; enable low mid-DELAY -> IDLE next edge, no echo, no echo_done.
